mig_ui_responder: RTL and testbench



---
 rtl/mig_ui_responder.sv | 132 +++++++++++++
 tb/tb_mig_ui_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mig_ui_responder.sv
// Memory-side model of the MIG 7-series app_* interface: calibration, refresh
// stalls, byte-masked writes and fixed-latency in-order reads over an on-chip array.
module mig_ui_responder #(
  parameter int MEM_DEPTH      = 2048,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [26:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  input  logic [127:0] app_wdf_data,
  input  logic         app_wdf_end,
  input  logic         app_wdf_wren,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_sr_req,
  input  logic         app_ref_req,
  input  logic         app_zq_req,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         app_sr_active,
  output logic         app_ref_ack,
  output logic         app_zq_ack,
  output logic         init_calib_complete,
  output logic         protocol_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] S_CALIB = 2'd0, S_RUN = 2'd1, S_REF = 2'd2;

  logic [1:0]  st, st_nxt;
  logic [31:0] cal_cnt, ref_cnt, stall_cnt;
  logic        ref_pend, ref_by_req, enter_ref, per_hit;
  logic        cmd_acc, wr_acc, rd_acc, err_now;
  logic [AW-1:0] idx;
  logic [127:0]  mem [MEM_DEPTH];
  logic [RD_LATENCY-1:0]        vld_pipe;
  logic [RD_LATENCY-1:0][127:0] dat_pipe;

  // Upper address bits fold away (wrap), self-refresh is never granted.
  logic unused_ok;
  assign unused_ok = ^{app_sr_req, app_addr};

  assign idx     = app_addr[AW+2:3];
  assign cmd_acc = app_en & app_rdy;
  assign wr_acc  = cmd_acc & app_wdf_rdy & (app_cmd == 3'b000) & app_wdf_wren;
  assign rd_acc  = cmd_acc & (app_cmd == 3'b001);
  assign err_now = (cmd_acc & ((app_addr[2:0] != 3'b000) | (app_cmd[2:1] != 2'b00)))
                 | (cmd_acc & (app_cmd == 3'b000) & ~app_wdf_wren)
                 | (app_wdf_wren & app_wdf_rdy & ~wr_acc)
                 | (app_wdf_end != app_wdf_wren);
  assign per_hit = (REFRESH_PERIOD != 0) && (ref_cnt == 32'(REFRESH_PERIOD - 1));

  always_comb begin
    st_nxt    = st;
    enter_ref = 1'b0;
    case (st)
      S_CALIB: if (cal_cnt == 32'(CALIB_CYCLES - 1)) st_nxt = S_RUN;
      S_RUN: if (per_hit || app_ref_req || ref_pend) begin
        st_nxt    = S_REF;
        enter_ref = 1'b1;
      end
      S_REF: if (stall_cnt == 32'(REFRESH_CYCLES - 1)) st_nxt = S_RUN;
      default: st_nxt = S_CALIB;
    endcase
  end

  // Ready flags come from the next-state decode so they stay pure flops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st                  <= S_CALIB;
      cal_cnt             <= '0;
      ref_cnt             <= '0;
      stall_cnt           <= '0;
      ref_pend            <= 1'b0;
      ref_by_req          <= 1'b0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      app_ref_ack         <= 1'b0;
      app_zq_ack          <= 1'b0;
      init_calib_complete <= 1'b0;
      protocol_err        <= 1'b0;
    end else begin
      st          <= st_nxt;
      app_rdy     <= (st_nxt == S_RUN);
      app_wdf_rdy <= (st_nxt == S_RUN);
      if (st == S_CALIB) cal_cnt <= cal_cnt + 32'd1;
      if (st == S_CALIB && st_nxt == S_RUN) init_calib_complete <= 1'b1;
      if (enter_ref)            ref_cnt <= '0;
      else if (st != S_CALIB)   ref_cnt <= ref_cnt + 32'd1;
      if (st == S_REF && st_nxt == S_REF) stall_cnt <= stall_cnt + 32'd1;
      else                                stall_cnt <= '0;
      if (enter_ref)        ref_pend <= 1'b0;
      else if (app_ref_req) ref_pend <= 1'b1;
      if (enter_ref) ref_by_req <= app_ref_req | ref_pend;
      app_ref_ack  <= (st == S_REF) && (st_nxt == S_RUN) && ref_by_req;
      app_zq_ack   <= app_zq_req;
      protocol_err <= protocol_err | err_now;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc)
      for (int b = 0; b < 16; b++)
        if (!app_wdf_mask[b]) mem[idx][b*8 +: 8] <= app_wdf_data[b*8 +: 8];
  end

  // Read return pipe; a reset flushes anything in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= mem[idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = dat_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = vld_pipe[RD_LATENCY-1];
  assign app_rd_data_end   = vld_pipe[RD_LATENCY-1];
  assign app_sr_active     = 1'b0;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder: calibration, write/read, mask, refresh,
// maintenance acks, wrap/error and reset during a read burst.
module tb_mig_ui_responder;
  localparam int LAT = 4;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic [26:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_wren = 1'b0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_sr_req = 1'b0, app_ref_req = 1'b0, app_zq_req = 1'b0;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
  logic [127:0] app_rd_data;
  logic         app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete, protocol_err;

  mig_ui_responder #(.MEM_DEPTH(2048), .RD_LATENCY(LAT), .CALIB_CYCLES(16),
                     .REFRESH_PERIOD(32), .REFRESH_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_wren(app_wdf_wren), .app_wdf_mask(app_wdf_mask), .app_sr_req(app_sr_req),
    .app_ref_req(app_ref_req), .app_zq_req(app_zq_req), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
    .init_calib_complete(init_calib_complete), .protocol_err(protocol_err));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  logic [127:0] exp_q[$];
  int           acc_q[$];

  // Return monitor: in order, exact latency, end tied to valid.
  always @(negedge clk_in) begin
    if (app_rd_data_valid) begin
      chk("rd_end", app_rd_data_end, 1);
      if (exp_q.size() == 0) chk("rd_unexp", 1, 0);
      else begin
        chk("rd_data", app_rd_data, exp_q.pop_front());
        chk("rd_lat", cyc - acc_q.pop_front(), LAT - 1);
      end
    end
  end

  // Refresh gap tracker: 8-cycle stalls, 32-cycle spacing when enabled.
  logic trk_en = 1'b0, per_chk = 1'b0, prev_rdy = 1'b1, have_fall = 1'b0;
  int   last_fall = 0, ack_cnt = 0;
  always @(negedge clk_in) begin
    if (app_ref_ack) ack_cnt++;
    if (trk_en) begin
      if (prev_rdy && !app_rdy) begin
        if (have_fall && per_chk) chk("ref_period", cyc - last_fall, 32);
        last_fall = cyc;
        have_fall = 1'b1;
      end
      if (!prev_rdy && app_rdy && have_fall) chk("ref_gap", cyc - last_fall, 8);
      prev_rdy = app_rdy;
    end
  end

  // Called at a negedge; holds the command until accepted, returns acceptance edge.
  task automatic issue(input logic [2:0] cmd, input logic [26:0] addr,
                       input logic [127:0] data, input logic [15:0] mask,
                       input logic wren, output int acc);
    logic ok;
    int   n;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr; app_wdf_data = data;
    app_wdf_mask = mask; app_wdf_wren = wren; app_wdf_end = wren;
    n = 0;
    do begin
      ok = app_rdy;
      @(negedge clk_in);
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("cmd_timeout", 0, 1);
    acc = cyc;
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic wr(input logic [26:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int acc;
    issue(3'b000, addr, data, mask, 1'b1, acc);
  endtask

  task automatic rd(input logic [26:0] addr, input logic [127:0] exp);
    int acc;
    issue(3'b001, addr, '0, '0, 1'b0, acc);
    exp_q.push_back(exp);
    acc_q.push_back(acc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("rd_drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    logic bad = 1'b0;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_outs", {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_ref_ack,
                     app_zq_ack, init_calib_complete, protocol_err, app_sr_active}, 0);
    chk("rst_rd_data", app_rd_data, 0);
    rst_n_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_in);
      if (i < 16) bad = bad | init_calib_complete | app_rdy | app_wdf_rdy;
    end
    chk("calib_pre", bad, 0);
    chk("calib_done", {init_calib_complete, app_rdy, app_wdf_rdy}, 3'b111);
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DW = 128'hA5A5_5A5A_1122_3344_5566_7788_99AA_BBCC;

  initial begin
    do_reset();
    trk_en = 1'b1; prev_rdy = 1'b1;

    wr(27'h40, D1, 16'h0000);
    rd(27'h40, D1);
    wr(27'h80, {128{1'b1}}, 16'h0000);
    wr(27'h80, '0, 16'h00FF);
    rd(27'h80, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    drain();
    chk("err_clean", protocol_err, 0);

    for (int i = 0; i < 8; i++) wr(27'((16 + i) * 8), pat(i), 16'h0000);
    per_chk = 1'b1;
    for (int i = 0; i < 80; i++) rd(27'((16 + (i % 8)) * 8), pat(i % 8));
    drain();
    per_chk = 1'b0;

    app_zq_req = 1'b1;
    @(negedge clk_in);
    app_zq_req = 1'b0;
    chk("zq_ack", app_zq_ack, 1);
    @(negedge clk_in);
    chk("zq_ack_pulse", app_zq_ack, 0);

    ack_cnt = 0;
    app_ref_req = 1'b1;
    @(negedge clk_in);
    app_ref_req = 1'b0;
    repeat (45) @(negedge clk_in);
    chk("ref_ack_once", ack_cnt, 1);

    wr(27'h4028, DW, 16'h0000);
    rd(27'h28, DW);
    drain();
    chk("wrap_no_err", protocol_err, 0);
    rd(27'h2B, DW);
    repeat (2) @(negedge clk_in);
    chk("err_set", protocol_err, 1);
    drain();
    repeat (10) @(negedge clk_in);
    chk("err_sticky", protocol_err, 1);

    trk_en = 1'b0;
    for (int i = 0; i < 4; i++) rd(27'h28, DW);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    exp_q.delete();
    acc_q.delete();
    do_reset();
    repeat (20) @(negedge clk_in);
    chk("post_rst_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
